mux41_rr_sel: RTL
=================

Name: mux41_rr_sel

Overview:
- Upstream select generator for the 4:1 mux stage (m41).
- Arbitrates among four request lines round-robin and drives the mux select pair s1/s0 with the granted channel index.
- Holds each grant for a programmable dwell time, or until the requester drops, so the downstream mux output switches only on clean, registered boundaries.

Parameters:
- DWELL, 4: maximum cycles a grant is held while another request is pending; legal range 1..255.
- CNT_W, $clog2(DWELL+1): dwell counter width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  4  request per channel; bit0 = a, bit1 = b, bit2 = c, bit3 = d.
- s1  out  1  select MSB to the mux; registered.
- s0  out  1  select LSB to the mux; registered.
- gnt  out  4  one-hot grant; all zeros when nothing is granted.
- gnt_vld  out  1  high while a channel is granted.
- switch_p  out  1  one-cycle pulse on the cycle a new grant first appears on the outputs.

Behaviour:
- Reset (async, while rst_n = 0):
  - s1 = s0 = 0, gnt = 0, gnt_vld = 0, switch_p = 0.
  - Priority pointer ptr = 0; dwell counter cnt = 0; state = IDLE.
- Release of rst_n takes effect at the next rising edge. Reset asserted mid-grant clears everything immediately; there is no drain.
- Pick function: the first set bit of req, searching from ptr upward and wrapping 3 -> 0.
- States: IDLE and GRANT.
- IDLE:
  - req = 0: remain in IDLE.
  - Otherwise: next edge -> GRANT with cur = pick(req); {s1,s0} = cur; gnt = 1 << cur; gnt_vld = 1; switch_p = 1; cnt = DWELL-1.
  - Latency from req to grant is 1 cycle.
- GRANT, evaluated every cycle in this priority order:
  1. req[cur] = 0 (release): ptr = cur+1 (mod 4).
     - Other requests pending: grant pick(req excluding cur) at the next edge. No idle bubble; switch_p = 1.
     - No other requests: -> IDLE, with gnt = 0 and gnt_vld = 0.
  2. cnt = 0 and another request pending (rotate): ptr = cur+1; grant the pick of the others at the next edge; switch_p = 1.
  3. cnt = 0 and no other request: keep cur; reload cnt = DWELL-1; no pulse.
  4. Otherwise: cnt decrements by 1.
- s1/s0 hold the last granted index while in IDLE. They never change without a new grant, so the downstream mux is not glitched.
- New requests appearing mid-grant do not pre-empt; they are only considered at a release or rotate.
- DWELL = 1: rotation is considered every cycle, giving a new grant every cycle when several channels request.
- Glitch-free: all outputs come straight from flops; no combinational path from req to any output.

Optional Feature:
- Macro: MUX41_SEL_LOCK_EN.
- Defined: adds input port lock (1 bit).
  - While lock = 1 in GRANT, dwell expiry is ignored and cnt holds.
  - Only a release (req[cur] = 0) ends the grant.
  - lock has no effect in IDLE.
- Undefined: no lock port; behaviour exactly as above.

Decomposition:
- Package mux41_pkg:
  - N_CH = 4, CH_W = 2.
  - State enum sel_state_t {IDLE, GRANT}.
  - Function for the one-hot grant from an index.
- One combinational sub-module rr_pick4:
  - Inputs: req[3:0], ptr[1:0], excl_en, excl_idx.
  - Outputs: idx[1:0], any.
  - Shared by the IDLE-entry, release and rotate paths.

Test Plan:
- Reset: rst_n = 0 with req = 4'b1111 -> s1s0 = 00, gnt = 0, gnt_vld = 0. After release, the first edge gives gnt = 0001, s1s0 = 00, switch_p = 1.
- Hold, DWELL = 4: req = 4'b1010 held -> channel 1 for 4 cycles (s1s0 = 01), then channel 3 for 4 (s1s0 = 11), then channel 1 again. switch_p pulses at each change.
- Release: grant on channel 2; drop req[2] with req = 4'b0001 -> next edge gnt = 0001, s1s0 = 00, no IDLE cycle between.
- Sole requester: req = 4'b0100 for 20 cycles -> gnt stays 0100, single switch_p. Drop req -> gnt_vld = 0 while s1s0 stays 10.
- Async reset mid-grant: rst_n pulsed low between edges during a grant on channel 3 -> outputs clear immediately, without waiting for an edge; ptr returns to 0.
- MUX41_SEL_LOCK_EN defined: lock = 1 with req = 4'b0011 and a grant on channel 0 -> channel 0 held beyond 4 cycles. Lowering lock -> rotates to channel 1 once cnt reaches 0.

Source files
------------

// File: rtl/mux41_pkg.sv
// Shared types and helpers for the mux41 round-robin select generator.
package mux41_pkg;

    localparam int unsigned N_CH = 4;
    localparam int unsigned CH_W = 2;

    typedef enum logic {IDLE, GRANT} sel_state_t;

    function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] idx);
        logic [N_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set request at or above ptr, wrapping 3 -> 0,
// optionally skipping one channel.
module rr_pick4
    import mux41_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    input  logic            excl_en,
    input  logic [CH_W-1:0] excl_idx,
    output logic [CH_W-1:0] idx,
    output logic            any
);

    logic [CH_W-1:0] k;

    always_comb begin
        idx = '0;
        any = 1'b0;
        k   = '0;
        for (int i = 0; i < N_CH; i++) begin
            k = ptr + CH_W'(i);
            if (!any && req[k] && !(excl_en && (k == excl_idx))) begin
                idx = k;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux41_rr_sel.sv
// Round-robin select generator for the 4:1 mux stage with dwell-limited grants.
// Optional MUX41_SEL_LOCK_EN adds a lock input that suspends dwell expiry.
module mux41_rr_sel
    import mux41_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] req,
`ifdef MUX41_SEL_LOCK_EN
    input  logic            lock,
`endif
    output logic            s1,
    output logic            s0,
    output logic [N_CH-1:0] gnt,
    output logic            gnt_vld,
    output logic            switch_p
);

    localparam int unsigned    CNT_W    = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

    sel_state_t      state_q, state_d;
    logic [CH_W-1:0] sel_q, sel_d;
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0] gnt_q, gnt_d;
    logic            vld_q, vld_d;
    logic            sw_q, sw_d;

    logic            lock_hold;
    logic [CH_W-1:0] pick_ptr;
    logic [CH_W-1:0] pick_idx;
    logic            pick_any;
    logic            take;

`ifdef MUX41_SEL_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    // In GRANT the search starts just past the current owner and skips it, so the
    // same picker serves release and rotation; in IDLE it starts at ptr.
    assign pick_ptr = (state_q == GRANT) ? sel_q + CH_W'(1) : ptr_q;

    rr_pick4 u_pick (
        .req      (req),
        .ptr      (pick_ptr),
        .excl_en  (state_q == GRANT),
        .excl_idx (sel_q),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        vld_d   = vld_q;
        sw_d    = 1'b0;
        take    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    take = 1'b1;
                end
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    ptr_d = sel_q + CH_W'(1);
                    if (pick_any) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        vld_d   = 1'b0;
                    end
                end else if (!lock_hold) begin
                    if (cnt_q == '0) begin
                        if (pick_any) begin
                            ptr_d = sel_q + CH_W'(1);
                            take  = 1'b1;
                        end else begin
                            cnt_d = CNT_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            state_d = GRANT;
            sel_d   = pick_idx;
            gnt_d   = onehot(pick_idx);
            vld_d   = 1'b1;
            sw_d    = 1'b1;
            cnt_d   = CNT_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            sw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            sw_q    <= sw_d;
        end
    end

    assign s1       = sel_q[1];
    assign s0       = sel_q[0];
    assign gnt      = gnt_q;
    assign gnt_vld  = vld_q;
    assign switch_p = sw_q;

endmodule
